// File: rtl/adc_avg_sequencer.sv
// Sequences ADC conversions and publishes the truncated mean of each 2**AVG_LOG2-sample batch.
// Registered outputs, one cycle behind the state decision; hold_enable parks the sequencer between conversions.
module adc_avg_sequencer #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold_enable,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_data,
    output logic                conv_start,
    output logic [DATA_W-1:0]   avg_out,
    output logic                avg_valid,
    output logic                timeout_err,
    output logic [1:0]          state_out,
    output logic [AVG_LOG2:0]   sample_cnt
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [AVG_LOG2:0] BATCH_N  = (AVG_LOG2 + 1)'(1 << AVG_LOG2);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_AVERAGE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cur, tmo_nxt;
    logic [AVG_LOG2:0]   cnt_nxt;
    logic                conv_nxt;
    logic [DATA_W-1:0]   avg_nxt;
    logic                avg_vld_nxt;
    logic                err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_START;
            acc         <= '0;
            tmo_cnt     <= '0;
            sample_cnt  <= '0;
            conv_start  <= 1'b0;
            avg_out     <= '0;
            avg_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            tmo_cnt     <= tmo_nxt;
            sample_cnt  <= cnt_nxt;
            conv_start  <= conv_nxt;
            avg_out     <= avg_nxt;
            avg_valid   <= avg_vld_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        tmo_nxt     = tmo_cnt;
        cnt_nxt     = sample_cnt;
        conv_nxt    = 1'b0;
        avg_nxt     = avg_out;
        avg_vld_nxt = 1'b0;
        err_nxt     = timeout_err;
        // conv_start marks the first WAIT cycle, so the wait count restarts there
        tmo_cur     = conv_start ? '0 : tmo_cnt;

        case (state)
            ST_START: begin
                if (hold_enable) begin
                    state_nxt = ST_HOLD;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_WAIT;
                    conv_nxt  = 1'b1;
                end
            end
            ST_WAIT: begin
                tmo_nxt = tmo_cur + TMO_W'(1);
                if (sample_valid) begin
                    acc_nxt   = acc + ACC_W'(sample_data);
                    cnt_nxt   = sample_cnt + 1'b1;
                    state_nxt = (cnt_nxt == BATCH_N) ? ST_AVERAGE : ST_START;
                end else if (tmo_cur == TMO_LAST) begin
                    // abandon this conversion but keep the partial batch for the retry
                    err_nxt   = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_AVERAGE: begin
                avg_nxt     = acc[ACC_W-1:AVG_LOG2];
                avg_vld_nxt = 1'b1;
                acc_nxt     = '0;
                cnt_nxt     = '0;
                state_nxt   = ST_START;
            end
            ST_HOLD: begin
                if (!hold_enable) state_nxt = ST_START;
            end
            default: state_nxt = ST_START;
        endcase
    end

    assign state_out = state;

endmodule
